// File: rtl/mul8_seq_pkg.sv
// Shared constants and types for the 8x8 sequential multiplier built on a 4x4 array core.
package mul8_seq_pkg;

  localparam int NIB_W  = 4;
  localparam int OP_W   = 8;
  localparam int PROD_W = 2 * OP_W;

  localparam logic [1:0] LAST_STEP = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Left shift applied to each nibble product, indexed by step.
  localparam logic [3:0] STEP_SHIFT [0:3] = '{4'd0, 4'd4, 4'd4, 4'd8};

endpackage

// File: rtl/mul8_seq_if.sv
// Operand/result handshake bundle between a requester (master) and the multiplier (slave).
interface mul8_seq_if;
  import mul8_seq_pkg::*;

  logic              start_valid;
  logic              start_ready;
  logic [OP_W-1:0]   a;
  logic [OP_W-1:0]   b;
  logic              abort;
  logic              res_valid;
  logic              res_ready;
  logic [PROD_W-1:0] product;
  logic              busy;

  modport master (
    output start_valid, a, b, abort, res_ready,
    input  start_ready, res_valid, product, busy
  );

  modport slave (
    input  start_valid, a, b, abort, res_ready,
    output start_ready, res_valid, product, busy
  );

endinterface

// File: rtl/array_multi.sv
// Combinational 4x4 unsigned array multiplier; zero latency, no flow control.
module array_multi
  import mul8_seq_pkg::*;
(
  input  logic [NIB_W-1:0]   a,
  input  logic [NIB_W-1:0]   b,
  output logic [2*NIB_W-1:0] p
);

  always_comb begin
    p = '0;
    for (int i = 0; i < NIB_W; i++) begin
      p = p + ({{NIB_W{1'b0}}, (a & {NIB_W{b[i]}})} << i);
    end
  end

endmodule

// File: rtl/mul8_seq.sv
// 8x8 unsigned multiplier time-sharing one 4x4 core: result 4 edges after accept,
// held in DONE until res_ready (or abort); start_ready only in IDLE.
module mul8_seq
  import mul8_seq_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  mul8_seq_if.slave bus
);

  state_e              state;
  logic [1:0]          step;
  logic [OP_W-1:0]     a_q;
  logic [OP_W-1:0]     b_q;
  logic [PROD_W-1:0]   acc;
  logic [PROD_W-1:0]   prod_q;
  logic [NIB_W-1:0]    a_nib;
  logic [NIB_W-1:0]    b_nib;
  logic [2*NIB_W-1:0]  nib_prod;
  logic [PROD_W-1:0]   acc_next;

  // step[1] picks the a nibble, step[0] the b nibble: lo*lo, lo*hi, hi*lo, hi*hi.
  assign a_nib = step[1] ? a_q[OP_W-1:NIB_W] : a_q[NIB_W-1:0];
  assign b_nib = step[0] ? b_q[OP_W-1:NIB_W] : b_q[NIB_W-1:0];

  array_multi u_array_multi (
    .a (a_nib),
    .b (b_nib),
    .p (nib_prod)
  );

  assign acc_next = acc + ({{(PROD_W-2*NIB_W){1'b0}}, nib_prod} << STEP_SHIFT[step]);

  assign bus.start_ready = (state == IDLE);
  assign bus.res_valid   = (state == DONE);
  assign bus.busy        = (state != IDLE);
  assign bus.product     = prod_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      step   <= 2'd0;
      a_q    <= '0;
      b_q    <= '0;
      acc    <= '0;
      prod_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_valid && bus.start_ready) begin
            a_q   <= bus.a;
            b_q   <= bus.b;
            acc   <= '0;
            step  <= 2'd0;
            state <= CALC;
          end
        end
        CALC: begin
          if (bus.abort) begin
            state <= IDLE;
          end else begin
            acc  <= acc_next;
            step <= step + 2'd1;
            if (step == LAST_STEP) begin
              prod_q <= acc_next;
              state  <= DONE;
            end
          end
        end
        DONE: begin
          // abort together with res_ready is still a completed handshake; both lead to IDLE.
          if (bus.res_ready || bus.abort) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul8_seq.sv
// Scoreboard bench for mul8_seq: directed latency/stall/abort/reset cases plus random back-to-back ops.
module tb_mul8_seq;

  logic clk;
  logic rst;
  logic rand_rdy;
  int   n_vec;
  int   n_miss;
  logic [15:0] exp_q [$];

  logic        hold_pend;
  logic [15:0] hold_val;

  mul8_seq_if bus ();

  mul8_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change 1ns after each rising edge; optionally randomise res_ready.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) bus.res_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic accept(input logic [7:0] av, input logic [7:0] bv, input bit push);
    bit ok;
    ok = 0;
    bus.start_valid = 1'b1;
    bus.a = av;
    bus.b = bv;
    for (int i = 0; i < 64; i++) begin
      if (bus.start_ready) begin
        ok = 1;
        break;
      end
      tick();
    end
    if (!ok) begin
      check_eq("accept_timeout", 32'd0, 32'd1);
      bus.start_valid = 1'b0;
      return;
    end
    tick();
    bus.start_valid = 1'b0;
    if (push) exp_q.push_back(16'(av) * 16'(bv));
  endtask

  task automatic wait_res(output int lat);
    lat = 0;
    while (!bus.res_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic [15:0] exp,
                        input bit idle_abort);
    int lat;
    if (idle_abort) bus.abort = 1'b1;
    accept(av, bv, 1);
    bus.abort = 1'b0;
    check_eq("busy_calc", 32'(bus.busy), 32'd1);
    check_eq("ready_calc", 32'(bus.start_ready), 32'd0);
    wait_res(lat);
    check_eq("latency", lat, 32'd4);
    check_eq("product", 32'(bus.product), 32'(exp));
    check_eq("busy_done", 32'(bus.busy), 32'd1);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check_eq("idle_after", 32'(bus.start_ready), 32'd1);
    check_eq("busy_after", 32'(bus.busy), 32'd0);
  endtask

  // Result monitor: compares every handshake against the scoreboard and checks DONE stability.
  always @(negedge clk) begin
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend && bus.res_valid) check_eq("hold_product", 32'(bus.product), 32'(hold_val));
      if (bus.res_valid && bus.res_ready) begin
        if (exp_q.size() == 0) check_eq("unexpected_result", 32'd1, 32'd0);
        else check_eq("sb_product", 32'(bus.product), 32'(exp_q.pop_front()));
      end
      hold_pend = bus.res_valid && !bus.res_ready && !bus.abort;
      hold_val  = bus.product;
    end
  end

  initial begin
    int lat;
    n_vec = 0;
    n_miss = 0;
    rand_rdy = 1'b0;
    hold_pend = 1'b0;
    hold_val = '0;
    bus.start_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.abort = 1'b0;
    bus.res_ready = 1'b0;
    rst = 1'b1;

    #3;
    check_eq("rst_start_ready", 32'(bus.start_ready), 32'd1);
    check_eq("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_product", 32'(bus.product), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // First accept lands on the first edge after reset release.
    run_op(8'h12, 8'h34, 16'h03A8, 0);
    run_op(8'hFF, 8'hFF, 16'hFE01, 0);
    run_op(8'h00, 8'hB7, 16'h0000, 1);

    // Stall in DONE with operands toggling and start_valid ignored.
    accept(8'hA5, 8'h5A, 1);
    wait_res(lat);
    check_eq("stall_latency", lat, 32'd4);
    for (int k = 0; k < 3; k++) begin
      bus.a = 8'($urandom);
      bus.b = 8'($urandom);
      bus.start_valid = 1'b1;
      tick();
      check_eq("stall_valid", 32'(bus.res_valid), 32'd1);
      check_eq("stall_product", 32'(bus.product), 32'h3A02);
      check_eq("stall_ready", 32'(bus.start_ready), 32'd0);
    end
    bus.start_valid = 1'b0;
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check_eq("stall_idle", 32'(bus.start_ready), 32'd1);

    // Asynchronous reset while in CALC step 2.
    accept(8'h12, 8'h34, 0);
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_res_valid", 32'(bus.res_valid), 32'd0);
    check_eq("arst_busy", 32'(bus.busy), 32'd0);
    check_eq("arst_start_ready", 32'(bus.start_ready), 32'd1);
    check_eq("arst_product", 32'(bus.product), 32'd0);
    rst = 1'b0;
    tick();
    for (int k = 0; k < 6; k++) begin
      tick();
      check_eq("arst_no_valid", 32'(bus.res_valid), 32'd0);
    end
    run_op(8'h12, 8'h34, 16'h03A8, 0);

    // Abort during CALC step 1.
    accept(8'h77, 8'h99, 0);
    tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check_eq("abort_busy", 32'(bus.busy), 32'd0);
    check_eq("abort_start_ready", 32'(bus.start_ready), 32'd1);
    for (int k = 0; k < 6; k++) begin
      tick();
      check_eq("abort_no_valid", 32'(bus.res_valid), 32'd0);
    end

    // Abort together with res_ready in DONE: one result, back to IDLE.
    accept(8'hA5, 8'h5A, 1);
    wait_res(lat);
    check_eq("abrdy_latency", lat, 32'd4);
    bus.abort = 1'b1;
    bus.res_ready = 1'b1;
    tick();
    bus.abort = 1'b0;
    bus.res_ready = 1'b0;
    check_eq("abrdy_idle", 32'(bus.start_ready), 32'd1);
    check_eq("abrdy_sb_empty", exp_q.size(), 32'd0);

    // Random back-to-back operations with random result stalls.
    rand_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      accept(8'($urandom), 8'($urandom), 1);
    end
    for (int k = 0; k < 200 && exp_q.size() > 0; k++) tick();
    rand_rdy = 1'b0;
    bus.res_ready = 1'b0;
    check_eq("drain", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
